// File: rtl/alu_ctrl_issue.sv
// alu_ctrl_issue: decodes ALUOp/funct into an ALU control code and issues it through a 2-entry skid buffer
module alu_ctrl_issue #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic [XLEN-1:0]  opa_in,
    input  logic [XLEN-1:0]  opb_in,
    input  logic [4:0]       rd_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_ctrl,
    output logic [XLEN-1:0]  opa,
    output logic [XLEN-1:0]  opb,
    output logic [4:0]       rd,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    typedef struct packed {
        logic [3:0]      ctrl;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
        logic            ill;
    } entry_t;
    localparam entry_t RST_ENTRY = '{ctrl: 4'b0010, a: '0, b: '0, rd: '0, ill: 1'b0};
    state_t           r_state, w_next;
    entry_t           r_out, r_skid, w_new;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       w_ctrl;
    logic             w_in_x, w_out_x;
    assign w_in_x      = in_valid && r_in_ready;
    assign w_out_x     = out_valid && out_ready;
    assign w_new       = '{ctrl: w_ctrl, a: opa_in, b: opb_in, rd: rd_in, ill: (w_ctrl == 4'b1111)};
    assign in_ready    = r_in_ready;
    assign out_valid   = (r_state != EMPTY);
    assign alu_ctrl    = r_out.ctrl;
    assign opa         = r_out.a;
    assign opb         = r_out.b;
    assign rd          = r_out.rd;
    assign illegal     = r_out.ill;
    assign illegal_cnt = r_cnt;
    // ALU control decode; only R-type lets funct7_5 turn ADD into SUB
    always_comb begin
        w_ctrl = 4'b0010;
        if (alu_op == 2'b01)
            w_ctrl = 4'b0110;
        else if (alu_op[1])
            case (funct3)
                3'b000:  w_ctrl = (funct7_5 && !alu_op[0]) ? 4'b0110 : 4'b0010;
                3'b001:  w_ctrl = 4'b0100;
                3'b100:  w_ctrl = 4'b0011;
                3'b101:  w_ctrl = funct7_5 ? 4'b0111 : 4'b0101;
                3'b110:  w_ctrl = 4'b0001;
                3'b111:  w_ctrl = 4'b0000;
                default: w_ctrl = 4'b1111;
            endcase
    end
    // Buffer occupancy transitions; flush overrides everything
    always_comb begin
        w_next = r_state;
        case (r_state)
            EMPTY:   w_next = w_in_x ? ONE : EMPTY;
            ONE:     w_next = (w_in_x && !w_out_x) ? TWO : (!w_in_x && w_out_x) ? EMPTY : ONE;
            TWO:     w_next = w_out_x ? ONE : TWO;
            default: w_next = EMPTY;
        endcase
        if (flush)
            w_next = EMPTY;
    end
    // State, registered in_ready and payload movement between skid and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
            r_out      <= RST_ENTRY;
            r_skid     <= RST_ENTRY;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != TWO);
            if ((r_state == EMPTY && w_in_x) || (r_state == ONE && w_in_x && w_out_x))
                r_out <= w_new;
            else if (r_state == TWO && w_out_x)
                r_out <= r_skid;
            if (r_state == ONE && w_in_x && !w_out_x)
                r_skid <= w_new;
        end
    end
    // Saturating count of accepted illegal ops, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (w_in_x && w_new.ill && r_cnt != '1)
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: tb/tb_alu_ctrl_issue.sv
// tb_alu_ctrl_issue: directed stimulus with a queue scoreboard checked by an output monitor
module tb_alu_ctrl_issue;
    logic        clk = 0, rst_n = 0, in_valid = 0, in_ready, funct7_5 = 0, flush = 0;
    logic        out_valid, out_ready = 0, illegal;
    logic [1:0]  alu_op = 0;
    logic [2:0]  funct3 = 0;
    logic [31:0] opa_in = 0, opb_in = 0, opa, opb;
    logic [4:0]  rd_in = 0, rd;
    logic [3:0]  alu_ctrl;
    logic [7:0]  illegal_cnt;

    typedef struct packed {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  r;
        logic        i;
    } ent_t;

    ent_t q[$];
    ent_t m_e;
    int   total = 0, passed = 0, exp_cnt = 0;

    logic [3:0] R0 [8] = '{4'h2, 4'h4, 4'hF, 4'hF, 4'h3, 4'h5, 4'h1, 4'h0};
    logic [3:0] R1 [8] = '{4'h6, 4'h4, 4'hF, 4'hF, 4'h3, 4'h7, 4'h1, 4'h0};
    logic [3:0] I1 [8] = '{4'h2, 4'h4, 4'hF, 4'hF, 4'h3, 4'h7, 4'h1, 4'h0};

    alu_ctrl_issue #(.XLEN(32), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5),
        .opa_in(opa_in), .opb_in(opb_in), .rd_in(rd_in), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
        .opa(opa), .opb(opb), .rd(rd), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Monitor: every EX-side transfer must match the oldest outstanding expected entry
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_out: got rd=%0d ctrl=%0h with no entry expected", rd, alu_ctrl);
            end else begin
                m_e = q.pop_front();
                chk("out_entry", {alu_ctrl, opa, opb, rd, illegal}, m_e);
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] r,
                        input logic [3:0] ec);
        int n = 0;
        alu_op = op; funct3 = f3; funct7_5 = f7; opa_in = a; opb_in = b; rd_in = r; in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", in_ready, 1);
        q.push_back({ec, a, b, r, ec == 4'hF});
        if (ec == 4'hF && exp_cnt < 255) exp_cnt++;
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1 chk("drain", q.size(), 0);
    endtask

    initial begin
        logic [3:0] ec;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_alu_ctrl", alu_ctrl, 4'b0010);
        chk("rst_opa", opa, 0);
        chk("rst_opb", opb, 0);
        chk("rst_rd", rd, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_cnt", illegal_cnt, 0);
        rst_n = 1;
        out_ready = 1;
        @(posedge clk);
        #1;
        send(2'b10, 3'b000, 1'b1, 32'd5, 32'd3, 5'd7, 4'b0110);
        chk("latency_out_valid", out_valid, 1);
        for (int op = 0; op < 4; op++)
            for (int f3 = 0; f3 < 8; f3++)
                for (int f7 = 0; f7 < 2; f7++) begin
                    ec = (op == 0) ? 4'h2 : (op == 1) ? 4'h6 :
                         (op == 2) ? (f7 != 0 ? R1[f3] : R0[f3]) : (f7 != 0 ? I1[f3] : R0[f3]);
                    send(op[1:0], f3[2:0], f7[0], 32'h1000 + op * 16 + f3 * 2 + f7,
                         32'hF000 - op * 16 - f3 * 2 - f7, 5'(op * 16 + f3 * 2 + f7), ec);
                end
        drain();
        chk("sweep_cnt", illegal_cnt, 8);
        out_ready = 0;
        send(2'b00, 3'b000, 1'b0, 32'h11, 32'h21, 5'd1, 4'h2);
        send(2'b00, 3'b000, 1'b0, 32'h12, 32'h22, 5'd2, 4'h2);
        alu_op = 2'b00; funct3 = 0; funct7_5 = 0; opa_in = 32'h13; opb_in = 32'h23; rd_in = 5'd3; in_valid = 1;
        repeat (3) begin
            @(negedge clk);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_rd", rd, 1);
            chk("hold_opa", opa, 32'h11);
        end
        @(posedge clk);
        #1 out_ready = 1;
        send(2'b00, 3'b000, 1'b0, 32'h13, 32'h23, 5'd3, 4'h2);
        drain();
        out_ready = 0;
        send(2'b01, 3'b000, 1'b0, 32'h81, 32'h91, 5'd8, 4'h6);
        send(2'b10, 3'b111, 1'b0, 32'h82, 32'h92, 5'd9, 4'h0);
        alu_op = 2'b10; funct3 = 3'b010; opa_in = 32'h83; opb_in = 32'h93; rd_in = 5'd10; in_valid = 1; flush = 1;
        @(posedge clk);
        #1 flush = 0; in_valid = 0;
        q.delete();
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_two_cnt", illegal_cnt, exp_cnt);
        out_ready = 1;
        repeat (4) @(posedge clk);
        #1 out_ready = 0;
        alu_op = 2'b11; funct3 = 3'b011; rd_in = 5'd11; in_valid = 1; flush = 1;
        @(posedge clk);
        #1 flush = 0; in_valid = 0;
        exp_cnt++;
        chk("flush_one_cnt", illegal_cnt, exp_cnt);
        chk("flush_one_out_valid", out_valid, 0);
        out_ready = 1;
        for (int i = 0; i < 260; i++)
            send(2'b10, 3'b010, 1'b0, 32'(i), 32'(i + 1), 5'(i), 4'hF);
        drain();
        chk("sat_cnt", illegal_cnt, 255);
        flush = 1;
        @(posedge clk);
        #1 flush = 0;
        chk("sat_after_flush", illegal_cnt, 255);
        out_ready = 0;
        send(2'b11, 3'b101, 1'b1, 32'hAA, 32'hBB, 5'd5, 4'h7);
        chk("pre_arst_valid", out_valid, 1);
        #3 rst_n = 0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_alu_ctrl", alu_ctrl, 4'b0010);
        chk("arst_cnt", illegal_cnt, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_rd", rd, 0);
        q.delete();
        exp_cnt = 0;
        #2 rst_n = 1;
        out_ready = 1;
        alu_op = 2'b01; funct3 = 0; funct7_5 = 0; opa_in = 32'h33; opb_in = 32'h44; rd_in = 5'd9; in_valid = 1;
        q.push_back({4'h6, 32'h33, 32'h44, 5'd9, 1'b0});
        @(posedge clk);
        #1 in_valid = 0;
        chk("post_rst_latency", out_valid, 1);
        drain();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_issue.md
Name: alu_ctrl_issue

Overview:
- ID/EX-side producer for the ALU's 4-bit control interface.
- Decodes ALUOp/funct3/funct7 into the ALU control code and carries the operands and rd along with it.
- Registers the result into a 2-entry ready/valid buffer (output register plus skid entry) feeding the EX stage.
- Supports stall, flush and illegal-op flagging, and keeps a saturating illegal-op counter for debug.

Parameters:
- XLEN, 32, operand width
- CNT_W, 8, width of illegal-op counter

Ports:
- clk  in  1  clock; rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode-side instruction valid
- in_ready  out  1  buffer can accept; registered
- alu_op  in  2  00 mem-addr, 01 branch, 10 R-type, 11 I-type ALU
- funct3  in  3  instruction funct3
- funct7_5  in  1  instruction bit 30
- opa_in  in  XLEN  operand A
- opb_in  in  XLEN  operand B (register or immediate)
- rd_in  in  5  destination register
- flush  in  1  synchronous pipeline flush
- out_valid  out  1  EX-side entry valid
- out_ready  in  1  EX stage consumes entry
- alu_ctrl  out  4  ALU control code
- opa  out  XLEN  operand A
- opb  out  XLEN  operand B
- rd  out  5  destination register
- illegal  out  1  entry decoded as unsupported
- illegal_cnt  out  CNT_W  saturating count of accepted illegal ops

Behaviour:
- Codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, ILLEGAL 1111.
- Decode for alu_op=00: ADD. funct fields are ignored.
- Decode for alu_op=01: SUB. funct fields are ignored.
- Decode for alu_op=10 (R-type):
  - funct3 000: ADD, or SUB if funct7_5=1.
  - funct3 001: SLL. 100: XOR. 110: OR. 111: AND.
  - funct3 101: SRL, or SRA if funct7_5=1.
  - funct3 010/011: ILLEGAL with illegal=1.
- Decode for alu_op=11 (I-type): same as R-type, except funct3 000 is always ADD (funct7_5 ignored). funct3 001/101 honour funct7_5 as for R-type.
- Transfers: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Latency: an entry accepted into an empty buffer appears on the outputs the next cycle.
- Buffer states: EMPTY, ONE (output register valid), TWO (output and skid valid).
  - EMPTY + in xfer -> ONE.
  - ONE + in xfer, no out xfer -> TWO.
  - ONE + out xfer, no in xfer -> EMPTY.
  - ONE + both -> ONE; the new entry loads the output register.
  - TWO + out xfer -> ONE; the skid entry moves to the output register.
  - in_ready=0 in TWO, so no input transfer occurs in that state.
- in_ready = (next state != TWO), registered. Entries leave in strict FIFO order.
- Output stability: while out_valid=1 and out_ready=0, all output payload is held unchanged.
- flush:
  - The next state is EMPTY and any input offered in the same cycle is dropped.
  - in_ready=1 and out_valid=0 the next cycle.
  - flush dominates simultaneous in/out transfers.
- illegal_cnt:
  - Increments on each accepted input that decodes illegal, including one accepted in a flush cycle.
  - Saturates at 2^CNT_W-1.
  - Only rst_n clears it; flush does not.
- Reset (async, rst_n low):
  - State EMPTY, out_valid=0, in_ready=1.
  - alu_ctrl=0010, opa=opb=0, rd=0, illegal=0, illegal_cnt=0.
  - Reset mid-transfer discards all entries; the first valid input after release is accepted on the first clk edge.
- Payload registers update only on transfer; no X propagates to outputs after reset.

Test Plan:
- Reset, then alu_op=10 funct3=000 funct7_5=1, opa=5, opb=3, rd=7, out_ready=1 -> next cycle out_valid=1, alu_ctrl=0110, opa=5, opb=3, rd=7, illegal=0.
- Sweep all alu_op/funct3/funct7_5 combinations with out_ready=1:
  - alu_op=11 funct3=000 funct7_5=1 -> 0010.
  - alu_op=11 funct3=101 funct7_5=1 -> 0111.
  - alu_op=10 funct3=010 -> 1111, illegal=1, illegal_cnt increments by 1.
- Hold out_ready=0 and push 3 back-to-back inputs (rd=1,2,3) -> in_ready drops after the 2nd; outputs stay at rd=1. Then raise out_ready -> rd=1 then rd=2 delivered on consecutive cycles, after which rd=3 is accepted.
- With the buffer in TWO, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, and the flushed and offered entries never appear on the outputs.
- Push 260 illegal ops with CNT_W=8 -> illegal_cnt=255 and stays there; flush leaves it at 255; rst_n low clears it to 0.
- Drop rst_n asynchronously between clock edges while the buffer is in ONE -> out_valid=0 and alu_ctrl=0010 immediately, without waiting for a clock edge.
